// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, synchronous imem reads, 2-entry in-order buffer to decode.
// Latency: issue at N, imem data at N+1, instr_valid at N+2; 1 instr/cycle sustained with instr_ready high.
// Backpressure: a credit check (buffered + in-flight - popped < 2) stops issue, so the buffer never overflows.
//
// Ports:
//   clk, rst                         rising-edge clock, asynchronous active-high reset
//   imem_req / imem_addr             word read request and its address (current fetch PC)
//   imem_rdata                       read data, one cycle after imem_req
//   redirect / redirect_pc           flush everything and restart fetch at redirect_pc (low 2 bits dropped)
//   instr_valid / instr_ready        buffer-head handshake with decode
//   instr / instr_pc / instr_pc4     head word, its PC and PC+4

// Generic synchronous FIFO with single-cycle flush.
// Latency: a push is visible at the head on the next cycle; head is combinational from storage.
// Backpressure: pop on empty is ignored; push on full is accepted only alongside a pop.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push_vld,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    output logic                         head_vld,
    output logic [WIDTH-1:0]             head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop & (cnt != '0);
    assign do_push = push_vld & ((cnt != CW'(DEPTH)) | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            // Storage is cleared too so the head reads as zero straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_vld = (cnt != '0);
    assign head_dat = mem[rd_ptr];
    assign count    = cnt;
endmodule

module fetch_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [ADDR_WIDTH-1:0] instr_pc4
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] pc4;
    } entry_t;

    logic [ADDR_WIDTH-1:0] fpc;
    logic [ADDR_WIDTH-1:0] rsp_pc;
    logic                  inflight;
    logic [1:0]            count;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [2:0]            used;
    logic [2:0]            limit;
    entry_t                push_ent;
    entry_t                head_ent;
    logic                  unused_rpc_lsb;

    // Target is forced word-aligned, so the low two bits are deliberately ignored.
    assign unused_rpc_lsb = ^redirect_pc[1:0];

    assign pop  = instr_valid & instr_ready;
    // A response arriving in a redirect cycle belongs to the old stream.
    assign push = inflight & ~redirect;

    // Credit check "count + inflight - pop < 2", rearranged to avoid an unsigned subtraction.
    assign used  = {1'b0, count} + {2'b00, inflight};
    assign limit = 3'd2 + {2'b00, pop};
    assign issue = ~rst & ~redirect & (used < limit);

    assign imem_req  = issue;
    assign imem_addr = fpc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc      <= RESET_PC;
            rsp_pc   <= '0;
            inflight <= 1'b0;
        end else if (redirect) begin
            fpc      <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fpc    <= fpc + ADDR_WIDTH'(4);
                rsp_pc <= fpc;
            end
        end
    end

    // PC+4 is stored with the entry so the head outputs are all zero out of reset.
    always_comb begin
        push_ent       = '0;
        push_ent.instr = imem_rdata;
        push_ent.pc    = rsp_pc;
        push_ent.pc4   = rsp_pc + ADDR_WIDTH'(4);
    end

    fetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (2)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect),
        .push_vld (push),
        .push_dat (push_ent),
        .pop      (pop),
        .head_vld (instr_valid),
        .head_dat (head_ent),
        .count    (count)
    );

    assign instr     = head_ent.instr;
    assign instr_pc  = head_ent.pc;
    assign instr_pc4 = head_ent.pc4;

`ifndef SYNTHESIS
    // The credit check must keep a response from ever landing on a full buffer.
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) push |-> (count != 2'd2));
`endif
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: RESET_PC = 0
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic [AW-1:0] instr_pc4;

    // DUT B: RESET_PC near the top of the address space
    logic          rst_b;
    logic          imem_req_b;
    logic [AW-1:0] imem_addr_b;
    logic [DW-1:0] imem_rdata_b;
    logic          redirect_b = 1'b0;
    logic [AW-1:0] redirect_pc_b = '0;
    logic          instr_valid_b;
    logic          instr_ready_b = 1'b1;
    logic [DW-1:0] instr_b;
    logic [AW-1:0] instr_pc_b;
    logic [AW-1:0] instr_pc4_b;

    logic [31:0] salt = '0;
    int total = 0;
    int bad   = 0;

    fetch_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .instr_pc4(instr_pc4));

    fetch_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .rst(rst_b), .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
        .redirect(redirect_b), .redirect_pc(redirect_pc_b), .instr_valid(instr_valid_b),
        .instr_ready(instr_ready_b), .instr(instr_b), .instr_pc(instr_pc_b), .instr_pc4(instr_pc4_b));

    function automatic logic [31:0] word(input logic [31:0] a, input logic [31:0] s);
        return a ^ s;
    endfunction

    // Synchronous instruction memories; junk when no request so a spurious push shows up.
    always @(posedge clk) imem_rdata   <= imem_req   ? word(imem_addr, salt)   : 32'hDEAD_BEEF;
    always @(posedge clk) imem_rdata_b <= imem_req_b ? word(imem_addr_b, salt) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_if(input string tag,
                          input logic a_req, input logic [31:0] a_addr, input logic a_v,
                          input logic [31:0] a_ins, input logic [31:0] a_pc, input logic [31:0] a_pc4,
                          input logic e_req, input logic [31:0] e_addr, input logic e_v,
                          input logic [31:0] e_ins, input logic [31:0] e_pc, input logic [31:0] e_pc4);
        chk({tag, ".req"}, {31'b0, a_req}, {31'b0, e_req});
        if (e_req) chk({tag, ".addr"}, a_addr, e_addr);
        chk({tag, ".valid"}, {31'b0, a_v}, {31'b0, e_v});
        if (e_v) begin
            chk({tag, ".instr"}, a_ins, e_ins);
            chk({tag, ".pc"}, a_pc, e_pc);
            chk({tag, ".pc4"}, a_pc4, e_pc4);
        end
    endtask

    task automatic chk_a(input string tag, input logic e_req, input logic [31:0] e_addr, input logic e_v,
                         input logic [31:0] e_ins, input logic [31:0] e_pc, input logic [31:0] e_pc4);
        chk_if(tag, imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc4,
               e_req, e_addr, e_v, e_ins, e_pc, e_pc4);
    endtask

    task automatic chk_b(input string tag, input logic e_req, input logic [31:0] e_addr, input logic e_v,
                         input logic [31:0] e_pc, input logic [31:0] e_pc4);
        chk_if(tag, imem_req_b, imem_addr_b, instr_valid_b, instr_b, instr_pc_b, instr_pc4_b,
               e_req, e_addr, e_v, e_pc, e_pc, e_pc4);
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, ".req"}, {31'b0, imem_req}, 32'h0);
        chk({tag, ".valid"}, {31'b0, instr_valid}, 32'h0);
        chk({tag, ".instr"}, instr, 32'h0);
        chk({tag, ".pc"}, instr_pc, 32'h0);
        chk({tag, ".pc4"}, instr_pc4, 32'h0);
    endtask

    // Called at a falling edge; returns at a falling edge with rst just released.
    task automatic do_reset();
        redirect    = 1'b0;
        instr_ready = 1'b0;
        rst         = 1'b1;
        #1;
        chk_zero_a("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive(input bit rdy, input bit rd, input logic [31:0] rpc);
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    typedef struct {
        bit          rst_before;
        bit          ready;
        bit          req;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] ins;
        logic [31:0] pc4;
    } vec_t;

    vec_t tbl [15];

    // Behavioural reference: buffered entries as queues, one optional outstanding read.
    logic [31:0] qpc [$];
    logic [31:0] qw  [$];
    logic [31:0] m_fpc;
    logic [31:0] m_ipc;
    bit          m_infl;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        rst_b = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;

        // Straight-line fetch, then 5-cycle stall after the first valid.
        tbl[0]  = '{1, 1, 1, 32'h00, 0, 32'h0, 32'h0};
        tbl[1]  = '{0, 1, 1, 32'h04, 0, 32'h0, 32'h0};
        tbl[2]  = '{0, 1, 1, 32'h08, 1, 32'h0, 32'h4};
        tbl[3]  = '{0, 1, 1, 32'h0C, 1, 32'h4, 32'h8};
        tbl[4]  = '{0, 1, 1, 32'h10, 1, 32'h8, 32'hC};
        tbl[5]  = '{1, 0, 1, 32'h00, 0, 32'h0, 32'h0};
        tbl[6]  = '{0, 0, 1, 32'h04, 0, 32'h0, 32'h0};
        tbl[7]  = '{0, 0, 0, 32'h00, 1, 32'h0, 32'h4};
        tbl[8]  = '{0, 0, 0, 32'h00, 1, 32'h0, 32'h4};
        tbl[9]  = '{0, 0, 0, 32'h00, 1, 32'h0, 32'h4};
        tbl[10] = '{0, 0, 0, 32'h00, 1, 32'h0, 32'h4};
        tbl[11] = '{0, 0, 0, 32'h00, 1, 32'h0, 32'h4};
        tbl[12] = '{0, 1, 1, 32'h08, 1, 32'h0, 32'h4};
        tbl[13] = '{0, 1, 1, 32'h0C, 1, 32'h4, 32'h8};
        tbl[14] = '{0, 1, 1, 32'h10, 1, 32'h8, 32'hC};

        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].rst_before) do_reset();
            drive(tbl[i].ready, 1'b0, '0);
            chk_a($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].valid,
                  tbl[i].ins, tbl[i].ins, tbl[i].pc4);
            next();
        end

        // Redirect to 0x103 while one word is buffered and one response is arriving.
        do_reset();
        drive(0, 0, '0);        chk_a("rd.c0", 1, 32'h0,   0, 0, 0, 0);                      next();
        drive(0, 0, '0);        chk_a("rd.c1", 1, 32'h4,   0, 0, 0, 0);                      next();
        drive(0, 1, 32'h103);   chk_a("rd.R",  0, 32'h0,   1, 32'h0, 32'h0, 32'h4);          next();
        drive(1, 0, '0);        chk_a("rd.R1", 1, 32'h100, 0, 0, 0, 0);                      next();
        drive(1, 0, '0);        chk_a("rd.R2", 1, 32'h104, 0, 0, 0, 0);                      next();
        drive(1, 0, '0);        chk_a("rd.R3", 1, 32'h108, 1, 32'h100, 32'h100, 32'h104);    next();
        drive(1, 0, '0);        chk_a("rd.R4", 1, 32'h10C, 1, 32'h104, 32'h104, 32'h108);    next();

        // Back-to-back redirects: 0x200 then 0x300, only 0x300 survives.
        do_reset();
        drive(1, 0, '0);        chk_a("bb.c0", 1, 32'h0,   0, 0, 0, 0);                      next();
        drive(1, 0, '0);        chk_a("bb.c1", 1, 32'h4,   0, 0, 0, 0);                      next();
        drive(1, 0, '0);        chk_a("bb.c2", 1, 32'h8,   1, 32'h0, 32'h0, 32'h4);          next();
        drive(1, 1, 32'h200);   chk_a("bb.R",  0, 32'h0,   1, 32'h4, 32'h4, 32'h8);          next();
        drive(1, 1, 32'h300);   chk_a("bb.R1", 0, 32'h0,   0, 0, 0, 0);                      next();
        drive(1, 0, '0);        chk_a("bb.R2", 1, 32'h300, 0, 0, 0, 0);                      next();
        drive(1, 0, '0);        chk_a("bb.R3", 1, 32'h304, 0, 0, 0, 0);                      next();
        drive(1, 0, '0);        chk_a("bb.R4", 1, 32'h308, 1, 32'h300, 32'h300, 32'h304);    next();
        drive(1, 0, '0);        chk_a("bb.R5", 1, 32'h30C, 1, 32'h304, 32'h304, 32'h308);    next();

        // Async reset between edges with a response outstanding.
        do_reset();
        drive(1, 0, '0);        chk_a("ar.c0", 1, 32'h0,   0, 0, 0, 0);                      next();
        drive(1, 0, '0);        chk_a("ar.c1", 1, 32'h4,   0, 0, 0, 0);                      next();
        drive(1, 0, '0);        chk_a("ar.c2", 1, 32'h8,   1, 32'h0, 32'h0, 32'h4);          next();
        #2;
        rst = 1'b1;
        #1;
        chk_zero_a("ar.async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(1, 0, '0);        chk_a("ar.p0", 1, 32'h0,   0, 0, 0, 0);                      next();
        drive(1, 0, '0);        chk_a("ar.p1", 1, 32'h4,   0, 0, 0, 0);                      next();
        drive(1, 0, '0);        chk_a("ar.p2", 1, 32'h8,   1, 32'h0, 32'h0, 32'h4);          next();
        drive(1, 0, '0);        chk_a("ar.p3", 1, 32'hC,   1, 32'h4, 32'h4, 32'h8);          next();

        // PC wrap on the second instance.
        chk("wrap.rst_valid", {31'b0, instr_valid_b}, 32'h0);
        chk("wrap.rst_pc4", instr_pc4_b, 32'h0);
        rst_b = 1'b0;
        #1;
        chk_b("wrap.c0", 1, 32'hFFFF_FFF8, 0, 0, 0);                                         next(); #1;
        chk_b("wrap.c1", 1, 32'hFFFF_FFFC, 0, 0, 0);                                         next(); #1;
        chk_b("wrap.c2", 1, 32'h0000_0000, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);                 next(); #1;
        chk_b("wrap.c3", 1, 32'h0000_0004, 1, 32'hFFFF_FFFC, 32'h0000_0000);                 next(); #1;
        chk_b("wrap.c4", 1, 32'h0000_0008, 1, 32'h0000_0000, 32'h0000_0004);                 next();

        // Randomised traffic against the queue model.
        salt = $urandom;
        do_reset();
        qpc.delete();
        qw.delete();
        m_fpc  = 32'h0;
        m_ipc  = 32'h0;
        m_infl = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            bit          rdy;
            bit          rd;
            bit          ev;
            bit          pp;
            bit          ereq;
            logic [31:0] rpc;
            rdy = ($urandom_range(0, 9) < 5);
            rd  = ($urandom_range(0, 19) == 0);
            rpc = $urandom;
            drive(rdy, rd, rpc);
            ev   = (qpc.size() != 0);
            pp   = ev & rdy;
            ereq = !rd && ((qpc.size() + int'(m_infl) - int'(pp)) < 2);
            chk_a("rnd", ereq, m_fpc, ev,
                  ev ? qw[0] : 32'h0, ev ? qpc[0] : 32'h0, ev ? qpc[0] + 32'd4 : 32'h0);
            if (rd) begin
                qpc.delete();
                qw.delete();
                m_infl = 1'b0;
                m_fpc  = rpc & ~32'h3;
            end else begin
                if (pp) begin
                    void'(qpc.pop_front());
                    void'(qw.pop_front());
                end
                if (m_infl) begin
                    qpc.push_back(m_ipc);
                    qw.push_back(word(m_ipc, salt));
                end
                if (ereq) begin
                    m_infl = 1'b1;
                    m_ipc  = m_fpc;
                    m_fpc  = m_fpc + 32'd4;
                end else begin
                    m_infl = 1'b0;
                end
            end
            next();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
